// File: rtl/dco_fll_ctrl_if.sv
// rtl/dco_fll_ctrl_if.sv - host-side configuration and status bundle of the DCO FLL controller
interface dco_fll_ctrl_if #(
    parameter int CODE_W = 8,
    parameter int CNT_W  = 12
) ();
    logic              ena;
    logic              start;
    logic              stop;
    logic              track_en;
    logic [CNT_W-1:0]  target;
    logic [CODE_W-1:0] dco_code;
    logic              busy;
    logic              locked;
    logic [CNT_W-1:0]  meas_cnt;
    logic              meas_valid;

    modport master (
        output ena, start, stop, track_en, target,
        input  dco_code, busy, locked, meas_cnt, meas_valid
    );

    modport slave (
        input  ena, start, stop, track_en, target,
        output dco_code, busy, locked, meas_cnt, meas_valid
    );
endinterface

// File: rtl/dco_fll_ctrl.sv
// rtl/dco_fll_ctrl.sv - FLL controller: SAR search of the DCO code, then +/-1 tracking with lock flag
module dco_fll_ctrl #(
    parameter int CODE_W     = 8,
    parameter int CNT_W      = 12,
    parameter int WIN_CYC    = 1024,
    parameter int SETTLE_CYC = 16,
    parameter int TOL        = 1,
    parameter int LOCK_N     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dco_clk,
    dco_fll_ctrl_if.slave bus
);
    localparam int CYC_W = $clog2((WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC);
    localparam int BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int LCK_W = $clog2(LOCK_N + 1);

    localparam logic [CYC_W-1:0]  L_SET_LAST = CYC_W'(SETTLE_CYC - 1);
    localparam logic [CYC_W-1:0]  L_WIN_LAST = CYC_W'(WIN_CYC - 1);
    localparam logic [BIT_W-1:0]  L_TOP_BIT  = BIT_W'(CODE_W - 1);
    localparam logic [LCK_W-1:0]  L_LOCK_N   = LCK_W'(LOCK_N);
    localparam logic [CNT_W:0]    L_TOL      = (CNT_W + 1)'(TOL);
    localparam logic [CODE_W-1:0] L_CODE_MAX = '1;
    localparam logic [CNT_W-1:0]  L_CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DECIDE} state_t;

    state_t r_state, w_state_nxt;

    logic              r_s1, r_s2, r_s3;
    logic              w_edge;
    logic [CYC_W-1:0]  r_cyc, w_cyc_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [CODE_W-1:0] r_code, w_code_nxt;
    logic [BIT_W-1:0]  r_bit, w_bit_nxt;
    logic              r_track, w_track_nxt;
    logic [LCK_W-1:0]  r_lock_cnt, w_lock_cnt_nxt;
    logic              r_locked, w_locked_nxt;
    logic [CNT_W-1:0]  r_meas, w_meas_nxt;
    logic              r_mv, w_mv_nxt;

    logic              w_abort;
    logic [CNT_W:0]    w_cnt_ext, w_tgt_ext, w_hi, w_lo;
    logic [CODE_W-1:0] w_code_dec, w_code_inc, w_sar_code;
    logic [BIT_W-1:0]  w_bit_dec;

    assign w_edge     = r_s2 & ~r_s3;
    assign w_abort    = ~bus.ena | bus.stop;
    assign w_cnt_ext  = {1'b0, r_cnt};
    assign w_tgt_ext  = {1'b0, bus.target};
    assign w_hi       = w_tgt_ext + L_TOL;
    assign w_lo       = (w_tgt_ext >= L_TOL) ? (w_tgt_ext - L_TOL) : '0;
    assign w_code_dec = (r_code == '0) ? r_code : (r_code - CODE_W'(1));
    assign w_code_inc = (r_code == L_CODE_MAX) ? r_code : (r_code + CODE_W'(1));
    assign w_bit_dec  = r_bit - BIT_W'(1);

    assign bus.dco_code   = r_code;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.locked     = r_locked;
    assign bus.meas_cnt   = r_meas;
    assign bus.meas_valid = r_mv;

    // Bring the DCO into the clk domain and keep one delayed copy for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= dco_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Trial code for the current SAR step: drop the bit under test when the DCO ran too fast
    always_comb begin
        w_sar_code = r_code;
        if (r_cnt > bus.target) begin
            w_sar_code[r_bit] = 1'b0;
        end
    end

    // Next-state and datapath decisions; an abort overrides everything except the held code
    always_comb begin
        w_state_nxt    = r_state;
        w_cyc_nxt      = r_cyc + CYC_W'(1);
        w_cnt_nxt      = r_cnt;
        w_code_nxt     = r_code;
        w_bit_nxt      = r_bit;
        w_track_nxt    = r_track;
        w_lock_cnt_nxt = r_lock_cnt;
        w_locked_nxt   = r_locked;
        w_meas_nxt     = r_meas;
        w_mv_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cyc_nxt = '0;
                if (bus.start && bus.ena && !bus.stop) begin
                    w_state_nxt            = S_SETTLE;
                    w_bit_nxt              = L_TOP_BIT;
                    w_code_nxt             = '0;
                    w_code_nxt[L_TOP_BIT]  = 1'b1;
                    w_track_nxt            = 1'b0;
                    w_lock_cnt_nxt         = '0;
                    w_locked_nxt           = 1'b0;
                end
            end
            S_SETTLE: begin
                if (r_cyc == L_SET_LAST) begin
                    w_state_nxt = S_MEASURE;
                    w_cyc_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            S_MEASURE: begin
                if (w_edge && (r_cnt != L_CNT_MAX)) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                if (r_cyc == L_WIN_LAST) begin
                    w_state_nxt = S_DECIDE;
                    w_cyc_nxt   = '0;
                end
            end
            S_DECIDE: begin
                w_meas_nxt = r_cnt;
                w_mv_nxt   = 1'b1;
                w_cyc_nxt  = '0;
                w_cnt_nxt  = '0;
                if (!r_track) begin
                    w_code_nxt = w_sar_code;
                    if (r_bit == '0) begin
                        if (bus.track_en) begin
                            w_track_nxt = 1'b1;
                            w_state_nxt = S_SETTLE;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_bit_nxt             = w_bit_dec;
                        w_code_nxt[w_bit_dec] = 1'b1;
                        w_state_nxt           = S_SETTLE;
                    end
                end else begin
                    if (w_cnt_ext > w_hi) begin
                        w_code_nxt     = w_code_dec;
                        w_lock_cnt_nxt = '0;
                        w_locked_nxt   = 1'b0;
                    end else if (w_cnt_ext < w_lo) begin
                        w_code_nxt     = w_code_inc;
                        w_lock_cnt_nxt = '0;
                        w_locked_nxt   = 1'b0;
                    end else begin
                        if (r_lock_cnt != L_LOCK_N) begin
                            w_lock_cnt_nxt = r_lock_cnt + LCK_W'(1);
                        end
                        if (w_lock_cnt_nxt == L_LOCK_N) begin
                            w_locked_nxt = 1'b1;
                        end
                    end
                    // An unchanged code needs no settling time
                    w_state_nxt = (w_code_nxt != r_code) ? S_SETTLE : S_MEASURE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort && (r_state != S_IDLE)) begin
            w_state_nxt    = S_IDLE;
            w_cyc_nxt      = '0;
            w_cnt_nxt      = r_cnt;
            w_code_nxt     = r_code;
            w_bit_nxt      = r_bit;
            w_track_nxt    = 1'b0;
            w_lock_cnt_nxt = '0;
            w_locked_nxt   = 1'b0;
            w_meas_nxt     = r_meas;
            w_mv_nxt       = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: timers, edge count, code, SAR bit, lock tracking and measurement outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc      <= '0;
            r_cnt      <= '0;
            r_code     <= '0;
            r_bit      <= '0;
            r_track    <= 1'b0;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
            r_meas     <= '0;
            r_mv       <= 1'b0;
        end else begin
            r_cyc      <= w_cyc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_code     <= w_code_nxt;
            r_bit      <= w_bit_nxt;
            r_track    <= w_track_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_locked   <= w_locked_nxt;
            r_meas     <= w_meas_nxt;
            r_mv       <= w_mv_nxt;
        end
    end
endmodule

// File: tb/tb_dco_fll_ctrl.sv
// tb/tb_dco_fll_ctrl.sv - self-checking bench for dco_fll_ctrl with a DCO plant and behavioural model
module tb_dco_fll_ctrl;
    localparam int CODE_W = 8;
    localparam int CNT_W  = 12;
    localparam int WIN    = 1024;
    localparam int SET    = 16;
    localparam int TOL    = 1;
    localparam int LOCK_N = 4;
    localparam int CODE_MAX = (1 << CODE_W) - 1;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic dco_clk = 1'b0;

    dco_fll_ctrl_if #(.CODE_W(CODE_W), .CNT_W(CNT_W)) bus ();

    dco_fll_ctrl #(
        .CODE_W(CODE_W), .CNT_W(CNT_W), .WIN_CYC(WIN),
        .SETTLE_CYC(SET), .TOL(TOL), .LOCK_N(LOCK_N)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .dco_clk(dco_clk),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: dut=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: no response within cycle budget at %0t", name, $time);
    endtask

    // DCO plant: phase accumulator gives exactly code+offset rising edges in any WIN consecutive cycles
    int offset = 0;
    int acc_g  = 0;
    bit h0 = 0, h1 = 0, h2 = 0;

    // Behavioural model: phase 0 idle, 1 settling, 2 measuring, 3 deciding; m_left counts cycles remaining
    int m_phase = 0, m_left = 0, m_acc = 0, m_code = 0, m_bit = 0, m_lock = 0, m_meas = 0;
    bit m_track = 0, m_locked = 0, m_mv = 0;
    int mv_pulses = 0;

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_acc = 0; m_code = 0; m_bit = 0;
        m_lock = 0; m_meas = 0; m_track = 0; m_locked = 0; m_mv = 0;
    endtask

    task automatic model_step(input bit e);
        int tgt, old;
        m_mv = 0;
        if (m_phase != 0 && (!bus.ena || bus.stop)) begin
            m_phase = 0; m_locked = 0; m_track = 0;
            return;
        end
        tgt = int'(bus.target);
        case (m_phase)
            0: if (bus.start && bus.ena && !bus.stop) begin
                m_phase = 1; m_left = SET; m_bit = CODE_W - 1;
                m_code = 1 << (CODE_W - 1); m_track = 0; m_lock = 0;
            end
            1: begin
                m_left--;
                if (m_left == 0) begin m_phase = 2; m_left = WIN; m_acc = 0; end
            end
            2: begin
                m_acc = (m_acc + e > CNT_MAX) ? CNT_MAX : m_acc + e;
                m_left--;
                if (m_left == 0) m_phase = 3;
            end
            default: begin
                m_meas = m_acc; m_mv = 1;
                if (!m_track) begin
                    if (m_acc > tgt) m_code -= (1 << m_bit);
                    if (m_bit == 0) begin
                        if (bus.track_en) begin m_track = 1; m_phase = 1; m_left = SET; end
                        else m_phase = 0;
                    end else begin
                        m_bit--; m_code += (1 << m_bit); m_phase = 1; m_left = SET;
                    end
                end else begin
                    old = m_code;
                    if (m_acc > tgt + TOL) begin
                        m_code = (m_code > 0) ? m_code - 1 : 0; m_lock = 0; m_locked = 0;
                    end else if (m_acc < tgt - TOL) begin
                        m_code = (m_code < CODE_MAX) ? m_code + 1 : CODE_MAX; m_lock = 0; m_locked = 0;
                    end else begin
                        if (m_lock < LOCK_N) m_lock++;
                        if (m_lock == LOCK_N) m_locked = 1;
                    end
                    if (m_code != old) begin m_phase = 1; m_left = SET; end
                    else begin m_phase = 2; m_left = WIN; m_acc = 0; end
                end
            end
        endcase
    endtask

    // Compare DUT against the model mid-cycle, then advance plant and model to the next rising edge
    always @(negedge clk) begin
        bit wrap;
        if (!rst_n) model_reset();
        check("dco_code",   bus.dco_code,   m_code);
        check("busy",       bus.busy,       (m_phase != 0));
        check("locked",     bus.locked,     m_locked);
        check("meas_valid", bus.meas_valid, m_mv);
        check("meas_cnt",   bus.meas_cnt,   m_meas);
        if (bus.meas_valid === 1'b1) mv_pulses++;
        acc_g += int'(bus.dco_code) + offset;
        wrap = 0;
        if (acc_g >= WIN) begin acc_g -= WIN; wrap = 1; end
        dco_clk = wrap;
        h2 = h1; h1 = h0; h0 = wrap;
        if (rst_n) model_step(h2);
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;
    endtask

    task automatic wait_busy_low(input int budget, output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < budget) begin cyc(1); n++; end
        if (bus.busy !== 1'b0) timeout_fail("busy_low_timeout");
    endtask

    task automatic wait_mv(input int budget);
        int n;
        n = 0;
        do begin cyc(1); n++; end while (bus.meas_valid !== 1'b1 && n < budget);
        if (bus.meas_valid !== 1'b1) timeout_fail("meas_valid_timeout");
    endtask

    initial begin
        int n, elapsed, tgt, k;
        int codes[8];
        bit lks[8];
        bus.ena = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.track_en = 1'b0; bus.target = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        // Reset while measuring: everything returns to reset values at once and stays there
        bus.target = 12'd100;
        pulse_start();
        cyc(100);
        check("pre_reset_code", bus.dco_code, 128);
        rst_n = 1'b0;
        #1;
        check("rst_code", bus.dco_code, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_mv", bus.meas_valid, 0);
        cyc(5);
        check("rst_hold_busy", bus.busy, 0);
        check("rst_hold_code", bus.dco_code, 0);
        rst_n = 1'b1;
        cyc(3);

        // SAR only, target 100
        bus.target = 12'd100; bus.track_en = 1'b0; mv_pulses = 0;
        pulse_start();
        wait_busy_low(10000, n);
        cyc(2);
        check("sar_latency", n, 8328);
        check("sar_code", bus.dco_code, 100);
        check("sar_pulses", mv_pulses, 8);

        // SAR then tracking; lock, disturb with offset, relock
        bus.track_en = 1'b1;
        pulse_start();
        n = 0;
        while (bus.locked !== 1'b1 && n < 20000) begin cyc(1); n++; end
        if (bus.locked !== 1'b1) timeout_fail("lock_timeout");
        check("lock_code", bus.dco_code, 100);
        wait_mv(3000);
        offset = 5;
        for (int i = 0; i < 8; i++) begin
            wait_mv(3000);
            codes[i] = int'(bus.dco_code);
            lks[i] = bus.locked;
        end
        check("trk_step0", codes[0], 99);
        check("trk_unlock", lks[0], 0);
        check("trk_step1", codes[1], 98);
        check("trk_step2", codes[2], 97);
        check("trk_step3", codes[3], 96);
        check("trk_hold", codes[6], 96);
        check("trk_not_yet", lks[6], 0);
        check("trk_relock", lks[7], 1);
        do_stop();
        check("stop_locked", bus.locked, 0);
        check("stop_busy", bus.busy, 0);
        offset = 0;
        cyc(2);

        // Code range limits: top of range and bottom of range while tracking
        bus.target = 12'd4095;
        pulse_start();
        for (int i = 0; i < 8; i++) wait_mv(3000);
        check("max_sar_code", bus.dco_code, 255);
        for (int i = 0; i < 3; i++) begin
            wait_mv(3000);
            check("max_trk_code", bus.dco_code, 255);
        end
        do_stop();
        offset = 5; bus.target = 12'd0;
        pulse_start();
        for (int i = 0; i < 8; i++) wait_mv(3000);
        check("min_sar_code", bus.dco_code, 0);
        for (int i = 0; i < 3; i++) begin
            wait_mv(3000);
            check("min_trk_code", bus.dco_code, 0);
        end
        do_stop();
        offset = 0; bus.track_en = 1'b0;
        cyc(2);

        // Stop mid-window, then simultaneous start and stop
        bus.target = 12'($urandom_range(0, 4095));
        mv_pulses = 0;
        pulse_start();
        cyc($urandom_range(20, 1000));
        do_stop();
        check("abort_busy", bus.busy, 0);
        check("abort_code", bus.dco_code, 128);
        cyc(50);
        check("abort_no_mv", mv_pulses, 0);
        bus.start = 1'b1; bus.stop = 1'b1;
        cyc(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        cyc(3);
        check("start_stop_idle", bus.busy, 0);

        // Enable dropped while settling
        pulse_start();
        cyc(5);
        bus.ena = 1'b0;
        cyc(1);
        bus.ena = 1'b1;
        check("ena_drop_busy", bus.busy, 0);
        check("ena_drop_code", bus.dco_code, 128);
        cyc(3);

        // Random target with repeated start requests while busy
        tgt = $urandom_range(0, 300);
        bus.target = 12'(tgt);
        mv_pulses = 0;
        pulse_start();
        elapsed = 0;
        for (int i = 0; i < 5; i++) begin
            k = $urandom_range(100, 1400);
            cyc(k);
            pulse_start();
            elapsed += k + 1;
        end
        wait_busy_low(10000, n);
        elapsed += n;
        cyc(2);
        check("rnd_latency", elapsed, 8328);
        check("rnd_code", bus.dco_code, (tgt > 255) ? 255 : tgt);
        check("rnd_pulses", mv_pulses, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
